ram_block_copier: RTL
=====================

Name: ram_block_copier

Overview:
- Bus master for the 32x8 data RAM; drives the RAM's MemWrite/MemRead/ReadAddress/WriteData pins and consumes MemData_out.
- Performs two operations on command: block copy (memmove semantics, overlap-safe) and block fill with a constant.
- Sits beside the CPU datapath, with the RAM port muxed to it while busy; the mux lives outside this block.

Parameters:
- DATA_W, 8, data width of RAM words.
- ADDR_W, 8, width of RAM address bus.
- DEPTH, 32, number of valid RAM words; addresses >= DEPTH are out of range.
- LEN_W, 6, width of length field; legal lengths are 0..DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- fill_mode  input  1  0 = copy, 1 = fill; latched with start.
- src_addr  input  ADDR_W  copy source base; ignored in fill mode.
- dst_addr  input  ADDR_W  destination base.
- length  input  LEN_W  number of words.
- fill_value  input  DATA_W  constant for fill mode.
- busy  output  1  high from the cycle after start until the last access cycle.
- done  output  1  single-cycle completion pulse.
- error  output  1  high together with done when the command was rejected.
- mem_read  output  1  to RAM MemRead.
- mem_write  output  1  to RAM MemWrite.
- mem_addr  output  ADDR_W  to RAM ReadAddress.
- mem_wdata  output  DATA_W  to RAM WriteData.
- mem_rdata  input  DATA_W  from RAM MemData_out; combinational read.

Behaviour:
- Reset:
  - Synchronous, active-high; state returns to IDLE.
  - All outputs are 0 in the cycle after reset is sampled.
  - Reset mid-operation aborts the command with no done pulse.
  - A write presented in the cycle where reset is sampled still commits in the RAM.
- FSM states: IDLE, READ, WRITE, FIN.
- IDLE, start=1:
  - Latch all command inputs.
  - If length==0: go to FIN with error=0.
  - If dst+length > DEPTH: go to FIN with error=1.
  - If copy mode and src+length > DEPTH: go to FIN with error=1.
  - Range checks use LEN_W+ADDR_W-bit sums, so no wrap.
  - Otherwise go to READ (copy) or WRITE (fill).
- Copy direction:
  - If dst > src, walk index i from length-1 down to 0 (descending).
  - Otherwise walk i from 0 up to length-1 (ascending).
  - dst == src performs the full read/write sequence.
- READ:
  - Drive mem_read=1 and mem_addr=src+i.
  - Capture mem_rdata into the data register at the clock edge.
  - Next state is WRITE.
- WRITE:
  - Drive mem_write=1, mem_addr=dst+i, mem_wdata=data register (copy) or latched fill_value (fill).
  - If this is the last index, go to FIN.
  - Otherwise step i and go to READ (copy) or stay in WRITE (fill).
- FIN:
  - done=1 for exactly one cycle; error=1 in the same cycle if rejected; busy=0.
  - Next state is IDLE.
- busy is 1 in READ and WRITE only.
- start is ignored outside IDLE, including in FIN.
- Latency, measured from the edge that samples start:
  - Copy of N words: 2N access cycles, then the FIN cycle; done appears 2N+1 cycles after that edge.
  - Fill of N words: N access cycles, then FIN.
  - Rejected or zero-length command: FIN immediately, so done appears 1 cycle after start.
- Never assert mem_read and mem_write in the same cycle.
- Outside READ/WRITE, mem_addr=0 and mem_wdata=0.
- All mem_* outputs and status outputs decode from registered state only; there is no combinational path from start or mem_rdata to any output.

Test Plan:
- Preload RAM[0..3]=11,22,33,44; copy src=0 dst=8 len=4 -> RAM[8..11]=11,22,33,44; done at cycle 9 after start; busy high for 8 cycles; RAM[0..3] unchanged.
- Preload RAM[4..7]=1,2,3,4; copy src=4 dst=5 len=4 (overlap) -> RAM[5..8]=1,2,3,4; first write address is 8 (descending); RAM[4]=1.
- Fill dst=0 len=32 value=0xA5 -> all 32 words = 0xA5; exactly 32 mem_write cycles; done 33 cycles after start; error=0.
- Commands: len=0 -> done=1, error=0 one cycle later, no mem_read/mem_write. Copy src=30 len=4 -> done=1, error=1, RAM untouched.
- Start copy len=8, assert reset on the 5th access cycle -> next cycle all outputs 0, state IDLE, no done pulse; new command afterwards completes normally.
- Pulse start again while busy with different addresses -> ignored; only the original command's writes occur, and exactly one done pulse is produced.

Source files
------------

// File: rtl/ram_block_copier.sv
// Bus master for the 32x8 data RAM: overlap-safe block copy (memmove) and constant block fill.
// All outputs decode from registered state; copy walks descending when dst > src to stay overlap-safe.
module ram_block_copier #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SUM_W = LEN_W + ADDR_W;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_e;

  state_e            state_q, state_d;
  logic              fill_q, fill_d;
  logic              desc_q, desc_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] fval_q, fval_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [SUM_W-1:0]  dst_end, src_end;
  logic              desc_n;
  logic              last_idx;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    desc_d  = desc_q;
    err_d   = err_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    fval_d  = fval_q;
    data_d  = data_q;

    // Sums are widened so an out-of-range command can never wrap into range.
    dst_end  = SUM_W'(dst_addr) + SUM_W'(length);
    src_end  = SUM_W'(src_addr) + SUM_W'(length);
    desc_n   = !fill_mode && (dst_addr > src_addr);
    last_idx = desc_q ? (idx_q == '0) : (idx_q == len_q - ONE_L);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          fill_d = fill_mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          fval_d = fill_value;
          desc_d = desc_n;
          idx_d  = desc_n ? (length - ONE_L) : '0;
          err_d  = 1'b0;
          if (length == '0) begin
            state_d = FIN;
          end else if ((dst_end > DEPTH_S) || (!fill_mode && (src_end > DEPTH_S))) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = fill_mode ? WRITE : READ;
          end
        end
      end
      READ: begin
        data_d  = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        if (last_idx) begin
          state_d = FIN;
        end else begin
          idx_d   = desc_q ? (idx_q - ONE_L) : (idx_q + ONE_L);
          state_d = fill_q ? WRITE : READ;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = src_q + ADDR_W'(idx_q);
      end
      WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_q + ADDR_W'(idx_q);
        mem_wdata = fill_q ? fval_q : data_q;
      end
      FIN: begin
        done  = 1'b1;
        error = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fill_q  <= 1'b0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      fval_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      fval_q  <= fval_d;
      data_q  <= data_d;
    end
  end

endmodule
